// File: rtl/bht_local_hist_pkg.sv
// Shared frontend types and index helpers for the
// local-history branch history table.
package bht_local_hist_pkg;

  localparam int unsigned BHT_ENTRIES  = 32;
  localparam int unsigned BHT_HIST     = 3;
  localparam int unsigned BHT_IPF      = 2;
  localparam int unsigned BHT_VLEN     = 32;
  localparam int unsigned BHT_ROWS     = BHT_ENTRIES / BHT_IPF;
  localparam int unsigned BHT_COL_BITS = $clog2(BHT_IPF);
  localparam int unsigned BHT_ROW_BITS = $clog2(BHT_ROWS);
  localparam int unsigned BHT_IDX_BITS = BHT_ROW_BITS + BHT_COL_BITS;
  localparam int unsigned BHT_NR_CNT   = 1 << BHT_HIST;

  typedef struct packed {
    logic                valid;
    logic [BHT_VLEN-1:0] pc;
    logic                taken;
  } bht_update_t;

  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef struct packed {
    logic                       valid;
    logic [BHT_HIST-1:0]        hist;
    logic [BHT_NR_CNT-1:0][1:0] cnt;
  } bht_entry_t;

  localparam bht_entry_t BHT_RST_ENTRY = '{
    valid: 1'b0,
    hist:  '0,
    cnt:   {BHT_NR_CNT{2'b01}}
  };

  function automatic logic [BHT_ROW_BITS-1:0] bht_row(
    input logic [BHT_VLEN-1:0] pc
  );
    return pc[1+BHT_COL_BITS +: BHT_ROW_BITS];
  endfunction

  function automatic logic [BHT_COL_BITS-1:0] bht_col(
    input logic [BHT_VLEN-1:0] pc
  );
    return pc[1 +: BHT_COL_BITS];
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// 2-bit saturating counter next value
// plus taken decode of the current value.
module bht_sat_counter (
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt,
  output logic       o_taken
);

  // Move toward the resolved direction, clamp at 0 and 3
  always_comb begin
    o_cnt = i_cnt;
    unique case (1'b1)
      (i_taken && i_cnt != 2'b11):  o_cnt = i_cnt + 2'd1;
      (!i_taken && i_cnt != 2'b00): o_cnt = i_cnt - 2'd1;
      default:                      o_cnt = i_cnt;
    endcase
    o_taken = i_cnt[1];
  end

endmodule

// File: rtl/bht_local_hist.sv
// Local-history BHT: zero-latency per-slot lookup,
// single resolved-branch update per cycle.
module bht_local_hist
  import bht_local_hist_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = BHT_ENTRIES,
  parameter int unsigned HIST_LEN        = BHT_HIST,
  parameter int unsigned INSTR_PER_FETCH = BHT_IPF,
  parameter int unsigned VLEN            = BHT_VLEN
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       upd_valid_i,
  input  logic [VLEN-1:0]            upd_pc_i,
  input  logic                       upd_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o
);

  bht_entry_t r_tab [NR_ENTRIES];

  bht_update_t              w_upd;
  logic [BHT_IDX_BITS-1:0] w_upd_idx;
  logic [BHT_ROW_BITS-1:0] w_row;
  bht_entry_t               w_base;
  bht_entry_t               w_new;
  logic [1:0]               w_sel_cnt;
  logic [1:0]               w_nxt_cnt;
  logic                     w_cnt_taken;
  logic                     w_unused;

  assign w_upd = '{
    valid: upd_valid_i & ~debug_mode_i,
    pc:    upd_pc_i,
    taken: upd_taken_i
  };

  assign w_upd_idx = {bht_row(w_upd.pc), bht_col(w_upd.pc)};
  assign w_row     = bht_row(vpc_i);

  assign w_unused = ^{vpc_i[0],
                      vpc_i[1 +: BHT_COL_BITS],
                      vpc_i[VLEN-1:1+BHT_IDX_BITS],
                      w_upd.pc[0],
                      w_upd.pc[VLEN-1:1+BHT_IDX_BITS],
                      w_cnt_taken};

  // Per-slot lookup: row from the fetch PC, column = slot
  for (genvar i = 0; i < INSTR_PER_FETCH; i++) begin : g_slot
    localparam logic [BHT_COL_BITS-1:0] LC = BHT_COL_BITS'(i);
    bht_entry_t      w_e;
    bht_prediction_t w_pred;
    assign w_e          = r_tab[{w_row, LC}];
    assign w_pred.valid = w_e.valid & ~rst_i;
    assign w_pred.taken = w_pred.valid & w_e.cnt[w_e.hist][1];
    assign pred_valid_o[i] = w_pred.valid;
    assign pred_taken_o[i] = w_pred.taken;
  end

  // Invalid entries train from a clean history and counters
  always_comb begin
    w_base = r_tab[w_upd_idx];
    if (!w_base.valid) begin
      w_base = BHT_RST_ENTRY;
    end
    w_sel_cnt = w_base.cnt[w_base.hist];
  end

  bht_sat_counter u_cnt (
    .i_cnt   (w_sel_cnt),
    .i_taken (w_upd.taken),
    .o_cnt   (w_nxt_cnt),
    .o_taken (w_cnt_taken)
  );

  // Build the trained entry: counter, shifted history, valid
  always_comb begin
    w_new                  = w_base;
    w_new.valid            = 1'b1;
    w_new.cnt[w_base.hist] = w_nxt_cnt;
    w_new.hist = HIST_LEN'({w_base.hist, w_upd.taken});
  end

  // Table state: flush clears valids only and beats update
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        r_tab[e] <= BHT_RST_ENTRY;
      end
    end else if (flush_bp_i) begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        r_tab[e].valid <= 1'b0;
      end
    end else if (w_upd.valid) begin
      r_tab[w_upd_idx] <= w_new;
    end
  end

endmodule
